// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-Stream switch family: arbiter FSM states and
// the cyclic round-robin index step used by both the arbiter and the switch.
package axis_switch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Next index after idx in a ring of count entries.
  function automatic int unsigned rr_next_index(input int unsigned idx,
                                                input int unsigned count);
    return (idx + 1 >= count) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index strictly after
// last_grant, wrapping around the ring.
module rr_arbiter
  import axis_switch_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = rr_next_index(32'(last_grant), N);
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && req[idx[IDX_W-1:0]]) begin
        grant       = idx[IDX_W-1:0];
        grant_valid = 1'b1;
      end
      idx = rr_next_index(idx, N);
    end
  end

endmodule

// File: rtl/axis_arbiter.sv
// Round-robin AXI-Stream N:1 arbiter with a single output register.
// Define AXIS_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet;
// otherwise the grant is released after every beat.
module axis_arbiter
  import axis_switch_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_USER_WIDTH = 10,
  parameter int T_ID_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [S_COUNT*T_ID_WIDTH-1:0]   s_id_i,
  input  logic [S_COUNT*T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_COUNT*T_USER_WIDTH-1:0] s_user_i,
  input  logic [S_COUNT-1:0]              s_last_i,
  input  logic [S_COUNT-1:0]              s_valid_i,
  output logic [S_COUNT-1:0]              s_ready_o,
  output logic [T_ID_WIDTH-1:0]           m_id_o,
  output logic [T_DATA_WIDTH-1:0]         m_data_o,
  output logic [T_USER_WIDTH-1:0]         m_user_o,
  output logic                            m_last_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [$clog2(S_COUNT)-1:0]      m_grant_o
);

  localparam int GW = $clog2(S_COUNT);

  arb_state_e          state, state_next;
  logic [GW-1:0]       grant, last_grant, rr_grant;
  logic                rr_valid;
  logic [S_COUNT-1:0]  ready;
  logic                accept;

  logic [T_ID_WIDTH-1:0]   sel_id;
  logic [T_DATA_WIDTH-1:0] sel_data;
  logic [T_USER_WIDTH-1:0] sel_user;
  logic                    sel_last;

  rr_arbiter #(
    .N     (S_COUNT),
    .IDX_W (GW)
  ) u_rr (
    .req         (s_valid_i),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign sel_id    = s_id_i[grant*T_ID_WIDTH +: T_ID_WIDTH];
  assign sel_data  = s_data_i[grant*T_DATA_WIDTH +: T_DATA_WIDTH];
  assign sel_user  = s_user_i[grant*T_USER_WIDTH +: T_USER_WIDTH];
  assign sel_last  = s_last_i[grant];
  assign s_ready_o = ready;

  // Only the granted input sees ready, and only when the output register can
  // take a beat this cycle; an idle cycle is spent arbitrating.
  always_comb begin
    state_next = state;
    ready      = '0;
    accept     = 1'b0;
    if (state == BUSY) begin
      ready[grant] = ~m_valid_o | m_ready_i;
      accept       = s_valid_i[grant] & ready[grant];
`ifdef AXIS_ARBITER_PKT_LOCK_EN
      if (accept && sel_last) state_next = IDLE;
`else
      if (accept) state_next = IDLE;
`endif
    end else if (rr_valid) begin
      state_next = BUSY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(S_COUNT - 1);
      m_valid_o  <= 1'b0;
      m_grant_o  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && rr_valid) begin
        grant      <= rr_grant;
        last_grant <= rr_grant;
      end
      if (accept) begin
        m_valid_o <= 1'b1;
        m_grant_o <= grant;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

  // Payload is qualified by m_valid_o, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_id_o   <= sel_id;
      m_data_o <= sel_data;
      m_user_o <= sel_user;
      m_last_o <= sel_last;
    end
  end

endmodule

// File: tb/tb_axis_arbiter.sv
// Scoreboard bench for axis_arbiter: per-input source queues drive the slaves,
// expected output beats are queued in arbitration order and popped on handshake.
`timescale 1ns/1ps
module tb_axis_arbiter;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int UW = 10;
  localparam int IW = 8;
  localparam int GW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [GW-1:0] src;
    logic [3:0]    gap;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [S*IW-1:0] s_id_i;
  logic [S*DW-1:0] s_data_i;
  logic [S*UW-1:0] s_user_i;
  logic [S-1:0]    s_last_i, s_valid_i, s_ready_o;
  logic [IW-1:0]   m_id_o;
  logic [DW-1:0]   m_data_o;
  logic [UW-1:0]   m_user_o;
  logic            m_last_o, m_valid_o, m_ready_i;
  logic [GW-1:0]   m_grant_o;

  beat_t src_q[S][$];
  exp_t  exp_q[$];

  int vectors = 0, miscompares = 0;
  int cycle = 0, last_out_cycle = 0;
  int drop_src = 0, drop_after = 0, hold_cnt = 0;
  logic [S-1:0] prev_acc;
  logic         prev_valid, prev_hs;
  logic [IW+DW+UW+GW:0] prev_payload;

  axis_arbiter #(
    .S_COUNT(S), .T_DATA_WIDTH(DW), .T_USER_WIDTH(UW), .T_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_id_i(s_id_i), .s_data_i(s_data_i), .s_user_i(s_user_i),
    .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_id_o(m_id_o), .m_data_o(m_data_o), .m_user_o(m_user_o),
    .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_grant_o(m_grant_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  function automatic beat_t mkBeat(input int src, input int idx, input int n, input int base);
    beat_t b;
    b.id   = IW'(src * 16 + idx);
    b.data = DW'(base + idx);
    b.user = UW'((base + idx) * 3 + src);
    b.last = (idx == n - 1);
    return b;
  endfunction

  task automatic addPacket(input int src, input int n, input int base);
    for (int i = 0; i < n; i++) src_q[src].push_back(mkBeat(src, i, n, base));
  endtask

  task automatic expectBeat(input int src, input int idx, input int n, input int base,
                            input int gap);
    exp_t e;
    e.b   = mkBeat(src, idx, n, base);
    e.src = GW'(src);
    e.gap = 4'(gap);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int k = 0; k < S; k++) begin
      beat_t b;
      b = '0;
      if (src_q[k].size() > 0) b = src_q[k][0];
      s_valid_i[k]           = (src_q[k].size() > 0) && !(k == drop_src && hold_cnt > 0);
      s_id_i[k*IW +: IW]     = b.id;
      s_data_i[k*DW +: DW]   = b.data;
      s_user_i[k*UW +: UW]   = b.user;
      s_last_i[k]            = b.last;
    end
  endtask

  // One clock: check outputs at the falling edge, then update sources after the rise.
  task automatic applyStimulus();
    logic [S-1:0] acc;
    exp_t e;
    @(negedge clk);
    checkOutput("ready_onehot", 64'($onehot0(s_ready_o)), 64'(1));
    if (m_valid_o && prev_valid && !prev_hs)
      checkOutput("stall_stable", 64'({m_id_o, m_data_o, m_user_o, m_last_o, m_grant_o}),
                  64'(prev_payload));
    if (m_valid_o && (!prev_valid || prev_hs))
      checkOutput("latency", 64'(prev_acc != 0), 64'(1));
    if (m_valid_o && !m_ready_i)
      checkOutput("stall_ready", 64'(s_ready_o), 64'(0));
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'(m_data_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat", 64'({m_id_o, m_data_o, m_user_o, m_last_o}), 64'(e.b));
        checkOutput("grant", 64'(m_grant_o), 64'(e.src));
        if (e.gap != 0) checkOutput("gap", 64'(cycle - last_out_cycle), 64'(e.gap));
      end
      last_out_cycle = cycle;
    end
    acc          = s_valid_i & s_ready_o;
    prev_acc     = acc;
    prev_valid   = m_valid_o;
    prev_hs      = m_valid_o & m_ready_i;
    prev_payload = {m_id_o, m_data_o, m_user_o, m_last_o, m_grant_o};
    @(posedge clk);
    #1;
    cycle++;
    if (hold_cnt > 0) hold_cnt--;
    for (int k = 0; k < S; k++)
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    if (acc[drop_src] && drop_after > 0) begin
      drop_after--;
      if (drop_after == 0) hold_cnt = 3;
    end
    drive();
  endtask

  task automatic runDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || m_valid_o) && n < budget) begin
      applyStimulus();
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (3) applyStimulus();
  endtask

  initial begin
    reset_n = 1'b0;
    m_ready_i = 1'b1;
    prev_acc = '0; prev_valid = 1'b0; prev_hs = 1'b0; prev_payload = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", 64'(m_valid_o), 64'(0));
    checkOutput("rst_s_ready", 64'(s_ready_o), 64'(0));
    checkOutput("rst_m_grant", 64'(m_grant_o), 64'(0));
    reset_n = 1'b1;

    // All inputs valid, 3-beat packets, input 0 has a second packet
    for (int s = 0; s < S; s++) addPacket(s, 3, s * 32);
    addPacket(0, 3, 128);
`ifdef AXIS_ARBITER_PKT_LOCK_EN
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 3; i++)
        expectBeat((p == 4) ? 0 : p, i, 3, (p == 4) ? 128 : p * 32,
                   (p == 0 && i == 0) ? 0 : ((i == 0) ? 2 : 1));
`else
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < S; s++) expectBeat(s, i, 3, s * 32, (i == 0 && s == 0) ? 0 : 2);
    for (int i = 0; i < 3; i++) expectBeat(0, i, 3, 128, 2);
`endif
    drive();
    runDrain(200);

    // Input 2 alone, data 0x10..0x13
    addPacket(2, 4, 8'h10);
`ifdef AXIS_ARBITER_PKT_LOCK_EN
    for (int i = 0; i < 4; i++) expectBeat(2, i, 4, 8'h10, (i == 0) ? 0 : 1);
`else
    for (int i = 0; i < 4; i++) expectBeat(2, i, 4, 8'h10, (i == 0) ? 0 : 2);
`endif
    drive();
    runDrain(100);

    // Output backpressure for 5 cycles mid-packet
    addPacket(0, 6, 8'h40);
    for (int i = 0; i < 6; i++) expectBeat(0, i, 6, 8'h40, 0);
    drive();
    repeat (4) applyStimulus();
    m_ready_i = 1'b0;
    repeat (5) applyStimulus();
    m_ready_i = 1'b1;
    runDrain(100);

    // Granted input 1 goes quiet for 3 cycles while input 3 waits
    drop_src = 1; drop_after = 2; hold_cnt = 0;
    addPacket(1, 5, 8'h50);
    addPacket(3, 2, 8'h60);
`ifdef AXIS_ARBITER_PKT_LOCK_EN
    for (int i = 0; i < 5; i++) expectBeat(1, i, 5, 8'h50, 0);
    for (int i = 0; i < 2; i++) expectBeat(3, i, 2, 8'h60, 0);
`else
    expectBeat(1, 0, 5, 8'h50, 0); expectBeat(3, 0, 2, 8'h60, 0);
    expectBeat(1, 1, 5, 8'h50, 0); expectBeat(3, 1, 2, 8'h60, 0);
    for (int i = 2; i < 5; i++) expectBeat(1, i, 5, 8'h50, 0);
`endif
    drive();
    runDrain(100);
    drop_after = 0;

    // Reset pulse mid-packet; stale beat and lock must vanish
    addPacket(2, 6, 8'h70);
    for (int i = 0; i < 6; i++) expectBeat(2, i, 6, 8'h70, 0);
    drive();
    repeat (4) applyStimulus();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", 64'(m_valid_o), 64'(0));
    checkOutput("midrst_s_ready", 64'(s_ready_o), 64'(0));
    checkOutput("midrst_m_grant", 64'(m_grant_o), 64'(0));
    exp_q.delete();
    for (int k = 0; k < S; k++) src_q[k].delete();
    prev_acc = '0; prev_valid = 1'b0; prev_hs = 1'b0;
    addPacket(1, 2, 8'h90);
    addPacket(3, 2, 8'hA0);
`ifdef AXIS_ARBITER_PKT_LOCK_EN
    expectBeat(1, 0, 2, 8'h90, 0); expectBeat(1, 1, 2, 8'h90, 0);
    expectBeat(3, 0, 2, 8'hA0, 0); expectBeat(3, 1, 2, 8'hA0, 0);
`else
    expectBeat(1, 0, 2, 8'h90, 0); expectBeat(3, 0, 2, 8'hA0, 0);
    expectBeat(1, 1, 2, 8'h90, 0); expectBeat(3, 1, 2, 8'hA0, 0);
`endif
    drive();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    runDrain(100);

    // Two 2-beat packets from inputs 0 and 1
    addPacket(0, 2, 8'hB0);
    addPacket(1, 2, 8'hC0);
`ifdef AXIS_ARBITER_PKT_LOCK_EN
    expectBeat(0, 0, 2, 8'hB0, 0); expectBeat(0, 1, 2, 8'hB0, 0);
    expectBeat(1, 0, 2, 8'hC0, 0); expectBeat(1, 1, 2, 8'hC0, 0);
`else
    expectBeat(0, 0, 2, 8'hB0, 0); expectBeat(1, 0, 2, 8'hC0, 0);
    expectBeat(0, 1, 2, 8'hB0, 0); expectBeat(1, 1, 2, 8'hC0, 0);
`endif
    drive();
    runDrain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_arbiter.md
AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 Parameter S_COUNT, default 4, number of AXI-Stream slave inputs (legal range 2..16).
REQ-002 Parameter T_DATA_WIDTH, default 8, tdata width per stream.
REQ-003 Parameter T_USER_WIDTH, default 10, tuser width per stream.
REQ-004 Parameter T_ID_WIDTH, default 8, tid width per stream.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 s_id_i  input  S_COUNT*T_ID_WIDTH  packed tid, slice k belongs to input k.
REQ-008 s_data_i  input  S_COUNT*T_DATA_WIDTH  packed tdata, slice k belongs to input k.
REQ-009 s_user_i  input  S_COUNT*T_USER_WIDTH  packed tuser, slice k belongs to input k.
REQ-010 s_last_i  input  S_COUNT  tlast per input.
REQ-011 s_valid_i  input  S_COUNT  tvalid per input.
REQ-012 s_ready_o  output  S_COUNT  tready per input.
REQ-013 m_id_o / m_data_o / m_user_o  output  T_ID_WIDTH / T_DATA_WIDTH / T_USER_WIDTH  merged stream payload.
REQ-014 m_last_o, m_valid_o  output  1 each; m_ready_i  input  1.
REQ-015 m_grant_o  output  $clog2(S_COUNT)  index of the input that produced the beat currently on m_*.

Function
REQ-016 FSM states: IDLE (no grant held), BUSY (grant held by one input).
REQ-017 IDLE: if any s_valid_i bit is set, the block SHALL select the lowest index strictly after last_grant (cyclically) with valid set, register it as grant and last_grant, and enter BUSY next cycle; s_ready_o SHALL be all-zero in IDLE.
REQ-018 BUSY: s_ready_o[grant] = ~m_valid_o | m_ready_i; every other s_ready_o bit SHALL be 0.
REQ-019 An accepted input beat SHALL appear on m_* with m_valid_o=1 on the next cycle (latency 1, single output register, full throughput within a packet).
REQ-020 m_* SHALL hold stable while m_valid_o=1 and m_ready_i=0; m_valid_o SHALL drop only after a m_valid_o&m_ready_i handshake with no new beat accepted.
REQ-021 BUSY -> IDLE on the cycle an input beat with s_last_i=1 is accepted; exactly one bubble cycle between packets.
REQ-022 Granted input deasserting s_valid_i mid-packet: stay BUSY indefinitely, no re-arbitration, no timeout.
REQ-023 Non-granted inputs SHALL never have a beat consumed; their valid/payload SHALL not affect m_*.
REQ-024 Payload is passed unmodified (tid, tdata, tuser, tlast).

Reset
REQ-025 While reset_n=0: state IDLE, m_valid_o=0, s_ready_o=0, m_grant_o=0, last_grant=S_COUNT-1 (input 0 has first priority); payload registers need no reset.
REQ-026 Reset mid-packet SHALL discard the in-flight beat and the lock; the first post-reset arbitration follows REQ-017.

Configuration
REQ-027 Macro AXIS_ARBITER_PKT_LOCK_EN: defined -> packet lock per REQ-021; undefined -> BUSY -> IDLE after every accepted beat regardless of s_last_i (beat-level round-robin interleave).

Structure
REQ-028 Shared package axis_switch_pkg SHALL hold the arbiter FSM state enum and a round-robin next-index function also used by the switch.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last_grant in; grant index, grant_valid out; purely combinational).

Verification
REQ-030 After reset, s_valid_i=4'b1111, all packets 3 beats -> packets appear in order 0,1,2,3,0; m_grant_o matches each beat; one bubble between packets.
REQ-031 Input 2 only, 4-beat packet data 0x10..0x13, m_ready_i=1 -> m_data_o 0x10..0x13 on 4 consecutive cycles, starting 1 cycle after first accept, m_last_o only on 0x13.
REQ-032 m_ready_i held 0 for 5 cycles mid-packet -> m_* frozen, s_ready_o[grant] low, no beat lost or duplicated.
REQ-033 Granted input 1 drops valid 3 cycles mid-packet while input 3 valid -> s_ready_o[3] stays 0, packet from 1 completes before 3 is granted.
REQ-034 reset_n pulsed low mid-packet -> m_valid_o=0 and s_ready_o=0 immediately; next grant goes to lowest valid index from 0.
REQ-035 AXIS_ARBITER_PKT_LOCK_EN undefined, inputs 0 and 1 each send 2-beat packets -> output beats alternate sources 0,1,0,1.
